// File: rtl/inst_writeback.sv
// inst_writeback: write-back stage downstream of execute.
// Holds each executed instruction for MEM_LAT cycles so that loads line up
// with the registered data-memory read data, then retires it into the
// register-file write port, the flag register and the retired counter.
// Also provides forwarding data and a load-use hazard signal to decode.
module inst_writeback #(
    parameter int MEM_LAT = 2,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              rw,
    input  logic              md,
    input  logic              fw,
    input  logic [REG_AW-1:0] dr,
    input  logic [31:0]       fout,
    input  logic [31:0]       memout,
    input  logic              v_in,
    input  logic              c_in,
    input  logic              n_in,
    input  logic              z_in,
    input  logic [REG_AW-1:0] sa,
    input  logic [REG_AW-1:0] sb,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [3:0]        flags,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [31:0]       fwd_a_data,
    output logic [31:0]       fwd_b_data,
    output logic              load_hazard,
    output logic [31:0]       retired
);

    // Index 0 is the newest entry, TAIL the oldest (the one about to retire).
    localparam int TAIL = MEM_LAT - 1;

    // Forwarding lookup result layout: {hit, hazard, data[31:0]}.
    // Walks the in-flight entries newest first, then the retiring register;
    // the first destination match decides. A pending load reports a hazard
    // instead of a hit. Register 0 never matches.
    function automatic logic [33:0] fwd_lookup(
        input logic [REG_AW-1:0]              src,
        input logic [MEM_LAT-1:0]             live,
        input logic [MEM_LAT-1:0]             is_load,
        input logic [MEM_LAT-1:0][REG_AW-1:0] dst,
        input logic [MEM_LAT-1:0][31:0]       data,
        input logic                           ret_we,
        input logic [REG_AW-1:0]              ret_addr,
        input logic [31:0]                    ret_data
    );
        logic [33:0] res;
        logic        found;
        res   = 34'd0;
        found = 1'b0;
        if (src != {REG_AW{1'b0}}) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                if (!found && live[i] && (dst[i] == src)) begin
                    found = 1'b1;
                    if (is_load[i]) begin
                        res = {1'b0, 1'b1, 32'd0};
                    end else begin
                        res = {1'b1, 1'b0, data[i]};
                    end
                end
            end
            if (!found && ret_we && (ret_addr == src)) begin
                res = {1'b1, 1'b0, ret_data};
            end
        end
        return res;
    endfunction

    // Pipeline storage
    logic [MEM_LAT-1:0]             valid_r;
    logic [MEM_LAT-1:0]             rw_r;
    logic [MEM_LAT-1:0]             md_r;
    logic [MEM_LAT-1:0]             fw_r;
    logic [MEM_LAT-1:0][REG_AW-1:0] dr_r;
    logic [MEM_LAT-1:0][31:0]       fout_r;
    logic [MEM_LAT-1:0][3:0]        vcnz_r;

    // Retirement registers
    logic              rf_we_r;
    logic [REG_AW-1:0] rf_waddr_r;
    logic [31:0]       rf_wdata_r;
    logic [3:0]        flags_r;
    logic [31:0]       retired_r;

    // Combinational helpers
    logic              rw_eff_s;
    logic [MEM_LAT-1:0] live_s;
    logic [31:0]       ret_data_s;
    logic              tail_wr_s;
    logic              tail_fw_s;
    logic [33:0]       fwd_a_s;
    logic [33:0]       fwd_b_s;

    // Register-0 writes are dropped at capture so nothing downstream sees them.
    always_comb begin
        rw_eff_s = 1'b0;
        if (dr != {REG_AW{1'b0}}) begin
            rw_eff_s = rw;
        end else begin
            rw_eff_s = 1'b0;
        end
    end

    // Shift the instruction pipeline by one stage every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {MEM_LAT{1'b0}};
            rw_r    <= {MEM_LAT{1'b0}};
            md_r    <= {MEM_LAT{1'b0}};
            fw_r    <= {MEM_LAT{1'b0}};
            dr_r    <= {(MEM_LAT*REG_AW){1'b0}};
            fout_r  <= {(MEM_LAT*32){1'b0}};
            vcnz_r  <= {(MEM_LAT*4){1'b0}};
        end else begin
            valid_r[0] <= valid_in;
            rw_r[0]    <= rw_eff_s;
            md_r[0]    <= md;
            fw_r[0]    <= fw;
            dr_r[0]    <= dr;
            fout_r[0]  <= fout;
            vcnz_r[0]  <= {v_in, c_in, n_in, z_in};
            for (int i = 1; i < MEM_LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                rw_r[i]    <= rw_r[i-1];
                md_r[i]    <= md_r[i-1];
                fw_r[i]    <= fw_r[i-1];
                dr_r[i]    <= dr_r[i-1];
                fout_r[i]  <= fout_r[i-1];
                vcnz_r[i]  <= vcnz_r[i-1];
            end
        end
    end

    // Tail decode: a load takes memout as it stands this cycle, else its fout.
    always_comb begin
        tail_wr_s = valid_r[TAIL] & rw_r[TAIL];
        tail_fw_s = valid_r[TAIL] & fw_r[TAIL];
        if (md_r[TAIL]) begin
            ret_data_s = memout;
        end else begin
            ret_data_s = fout_r[TAIL];
        end
    end

    // Retire the tail entry into the write port, flags and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {REG_AW{1'b0}};
            rf_wdata_r <= 32'd0;
            flags_r    <= 4'b0000;
            retired_r  <= 32'd0;
        end else begin
            rf_we_r <= tail_wr_s;
            if (tail_wr_s) begin
                rf_waddr_r <= dr_r[TAIL];
                rf_wdata_r <= ret_data_s;
            end
            if (tail_fw_s) begin
                flags_r <= vcnz_r[TAIL];
            end
            if (valid_r[TAIL]) begin
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    // Forwarding search for both decode source operands.
    always_comb begin
        live_s  = valid_r & rw_r;
        fwd_a_s = fwd_lookup(sa, live_s, md_r, dr_r, fout_r,
                             rf_we_r, rf_waddr_r, rf_wdata_r);
        fwd_b_s = fwd_lookup(sb, live_s, md_r, dr_r, fout_r,
                             rf_we_r, rf_waddr_r, rf_wdata_r);
    end

    assign rf_we       = rf_we_r;
    assign rf_waddr    = rf_waddr_r;
    assign rf_wdata    = rf_wdata_r;
    assign flags       = flags_r;
    assign retired     = retired_r;
    assign fwd_a_hit   = fwd_a_s[33];
    assign fwd_b_hit   = fwd_b_s[33];
    assign fwd_a_data  = fwd_a_s[31:0];
    assign fwd_b_data  = fwd_b_s[31:0];
    assign load_hazard = fwd_a_s[32] | fwd_b_s[32];

endmodule

// File: tb/tb_inst_writeback.sv
// Bench for inst_writeback: directed scenarios followed by randomized traffic,
// all checked against a queue-based behavioural model of the stage.
module tb_inst_writeback;

    localparam int MEM_LAT = 2;
    localparam int AW      = 5;

    logic          clk = 1'b0;
    logic          rst, valid_in, rw, md, fw;
    logic [AW-1:0] dr, sa, sb;
    logic [31:0]   fout, memout;
    logic          v_in, c_in, n_in, z_in;
    logic          rf_we, fwd_a_hit, fwd_b_hit, load_hazard;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata, fwd_a_data, fwd_b_data, retired;
    logic [3:0]    flags;

    inst_writeback #(.MEM_LAT(MEM_LAT), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rw(rw), .md(md), .fw(fw),
        .dr(dr), .fout(fout), .memout(memout),
        .v_in(v_in), .c_in(c_in), .n_in(n_in), .z_in(z_in),
        .sa(sa), .sb(sb),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags(flags),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .load_hazard(load_hazard), .retired(retired)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Behavioural model: queue of in-flight instructions, newest at index 0.
    typedef struct {
        logic          valid;
        logic          rw;
        logic          md;
        logic          fw;
        logic [AW-1:0] dr;
        logic [31:0]   fout;
        logic [3:0]    f;
    } ins_t;

    ins_t          hist[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_flags;
    logic [31:0]   m_retired;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ins_t e;
        e.valid = 1'b0; e.rw = 1'b0; e.md = 1'b0; e.fw = 1'b0;
        e.dr = '0; e.fout = 32'd0; e.f = 4'd0;
        hist.delete();
        for (int i = 0; i < MEM_LAT; i++) hist.push_front(e);
        m_we = 1'b0; m_waddr = '0; m_wdata = 32'd0; m_flags = 4'd0; m_retired = 32'd0;
    endtask

    // What happens at one rising edge, given the inputs currently driven.
    task automatic model_edge();
        ins_t r, n;
        if (rst) begin
            model_reset();
        end else begin
            r = hist[MEM_LAT-1];
            if (r.valid && r.rw && r.dr != '0) begin
                m_we    = 1'b1;
                m_waddr = r.dr;
                m_wdata = r.md ? memout : r.fout;
            end else begin
                m_we = 1'b0;
            end
            if (r.valid && r.fw) m_flags = r.f;
            if (r.valid) m_retired = m_retired + 32'd1;
            void'(hist.pop_back());
            n.valid = valid_in; n.rw = rw; n.md = md; n.fw = fw;
            n.dr = dr; n.fout = fout; n.f = {v_in, c_in, n_in, z_in};
            hist.push_front(n);
        end
    endtask

    task automatic fwd_model(input logic [AW-1:0] src, output logic hit,
                             output logic haz, output logic [31:0] data);
        bit done = 0;
        hit = 1'b0; haz = 1'b0; data = 32'd0;
        if (src != '0) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                if (!done && hist[i].valid && hist[i].rw && hist[i].dr == src) begin
                    done = 1;
                    if (hist[i].md) haz = 1'b1;
                    else begin hit = 1'b1; data = hist[i].fout; end
                end
            end
            if (!done && m_we && m_waddr == src) begin
                hit = 1'b1; data = m_wdata;
            end
        end
    endtask

    task automatic check_regs();
        check_val("rf_we",    {31'd0, rf_we},    {31'd0, m_we});
        check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        check_val("rf_wdata", rf_wdata,          m_wdata);
        check_val("flags",    {28'd0, flags},    {28'd0, m_flags});
        check_val("retired",  retired,           m_retired);
    endtask

    task automatic check_fwd();
        logic        ha, hb, za, zb;
        logic [31:0] da, db;
        fwd_model(sa, ha, za, da);
        fwd_model(sb, hb, zb, db);
        check_val("fwd_a_hit",   {31'd0, fwd_a_hit},   {31'd0, ha});
        check_val("fwd_a_data",  fwd_a_data,           da);
        check_val("fwd_b_hit",   {31'd0, fwd_b_hit},   {31'd0, hb});
        check_val("fwd_b_data",  fwd_b_data,           db);
        check_val("load_hazard", {31'd0, load_hazard}, {31'd0, za | zb});
    endtask

    // Drive one cycle of inputs, check forwarding, clock, check retirement.
    task automatic cyc(input logic v, input logic r, input logic m, input logic f,
                       input logic [AW-1:0] d, input logic [31:0] fo, input logic [3:0] fl,
                       input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [31:0] mem);
        valid_in = v; rw = r; md = m; fw = f; dr = d; fout = fo;
        {v_in, c_in, n_in, z_in} = fl;
        sa = a; sb = b; memout = mem;
        #1;
        check_fwd();
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 32'd0, 4'd0, a, b, 32'd0);
    endtask

    initial begin
        logic [31:0] mem;
        rst = 1'b1; valid_in = 1'b0; rw = 1'b0; md = 1'b0; fw = 1'b0;
        dr = '0; fout = 32'd0; memout = 32'd0; sa = '0; sb = '0;
        {v_in, c_in, n_in, z_in} = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check_regs();
        #1;
        check_fwd();
        rst = 1'b0;

        // ALU op to r3
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h12, 4'd0, 5'd0, 5'd0, 32'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check_val("alu_we",      {31'd0, rf_we}, 32'd1);
        check_val("alu_waddr",   {27'd0, rf_waddr}, 32'd3);
        check_val("alu_wdata",   rf_wdata, 32'h12);
        check_val("alu_retired", retired, 32'd1);

        // Load to r5, decode reads r5 right behind it
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 4'd0, 5'd0, 5'd0, 32'd0);
        sa = 5'd5;
        #1;
        check_val("ld_hazard", {31'd0, load_hazard}, 32'd1);
        check_val("ld_a_hit",  {31'd0, fwd_a_hit},   32'd0);
        idle(5'd5, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 5'd0, 5'd0, 32'hDEADBEEF);
        check_val("ld_wdata", rf_wdata, 32'hDEADBEEF);

        // Back-to-back writes to r7: newest must forward, retire in order
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'd1, 4'd0, 5'd0, 5'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'd2, 4'd0, 5'd0, 5'd7, 32'd0);
        sb = 5'd7;
        #1;
        check_val("b2b_fwd_b", fwd_b_data, 32'd2);
        idle(5'd0, 5'd7);
        check_val("b2b_first", rf_wdata, 32'd1);
        idle(5'd0, 5'd7);
        check_val("b2b_second", rf_wdata, 32'd2);

        // Write to r0 is dropped but still retires
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF, 4'd0, 5'd0, 5'd0, 32'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check_val("r0_we",      {31'd0, rf_we}, 32'd0);
        check_val("r0_retired", retired, 32'd5);

        // Flag update followed by a non-updating op
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 4'b1010, 5'd0, 5'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'b0101, 5'd0, 5'd0, 32'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check_val("flags_held", {28'd0, flags}, 32'd10);

        // Reset with two loads in flight
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd9,  32'd0, 4'd0, 5'd0, 5'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'd0, 4'd0, 5'd0, 5'd0, 32'd0);
        rst = 1'b1;
        idle(5'd9, 5'd10);
        rst = 1'b0;
        check_val("rst_flags",   {28'd0, flags}, 32'd0);
        check_val("rst_retired", retired, 32'd0);
        idle(5'd9, 5'd10);
        check_val("rst_no_we",   {31'd0, rf_we}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h55, 4'd0, 5'd0, 5'd0, 32'hABCD);
        idle(5'd4, 5'd0);
        idle(5'd0, 5'd0);
        check_val("post_rst_wdata",   rf_wdata, 32'h55);
        check_val("post_rst_retired", retired, 32'd1);

        // Randomized traffic; memout is X whenever no valid load is at the tail
        for (int n = 0; n < 3000; n++) begin
            if (hist[MEM_LAT-1].valid && hist[MEM_LAT-1].md) mem = $urandom;
            else mem = 'x;
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), mem);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
